// File: rtl/data_mem_ctrl_if.sv
// Request/response bus between a load/store unit and data_mem_ctrl.
// The master issues one access at a time; the controller answers with a
// single-cycle done pulse carrying load data and the fault flag.
interface data_mem_ctrl_if #(
    parameter int ADDR_W = 32
) ();
    logic              req;
    logic              we;
    logic [2:0]        size;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wd;
    logic              ready;
    logic              done;
    logic [31:0]       rd;
    logic              err;

    modport master (
        output req, we, size, addr, wd,
        input  ready, done, rd, err
    );

    modport slave (
        input  req, we, size, addr, wd,
        output ready, done, rd, err
    );
endinterface

// File: rtl/data_mem_ctrl.sv
// Data memory controller: word-organised storage with byte/half/word
// little-endian access, a fixed programmable latency and fault detection
// for misaligned, illegal-size and out-of-range accesses.
module data_mem_ctrl #(
    parameter int ADDR_W      = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input logic            clk,
    input logic            reset,
    data_mem_ctrl_if.slave bus
);
    localparam int                IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [ADDR_W-1:0] DEPTH_L  = ADDR_W'(DEPTH_WORDS);
    localparam logic [3:0]        CNT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state_r;
    logic [3:0]        cnt_r;
    logic              we_r;
    logic [2:0]        size_r;
    logic [ADDR_W-1:0] addr_r;
    logic [31:0]       wd_r;
    logic              ready_r;
    logic              done_r;
    logic              err_r;
    logic [31:0]       rd_r;

    logic [31:0]       mem_r [DEPTH_WORDS];

    logic              cur_we_s;
    logic [2:0]        cur_size_s;
    logic [ADDR_W-1:0] cur_addr_s;
    logic [31:0]       cur_wd_s;
    logic [IDX_W-1:0]  idx_s;
    logic              oor_s;
    logic              fault_s;
    logic [31:0]       resp_rd_s;
    logic [3:0]        be_s;
    logic [31:0]       wdata_s;
    logic [31:0]       mask_s;
    logic              accept_s;
    logic              enter_resp_s;
    logic              write_en_s;

    // Select the addressed byte/half/word of a memory word and extend it.
    function automatic logic [31:0] extract_load(input logic [31:0] word,
                                                 input logic [2:0]  size,
                                                 input logic [1:0]  ofs);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        b = word[{ofs, 3'b000} +: 8];
        h = ofs[1] ? word[31:16] : word[15:0];
        case (size)
            3'b000:  res = {{24{b[7]}}, b};
            3'b001:  res = {{16{h[15]}}, h};
            3'b010:  res = word;
            3'b100:  res = {24'h000000, b};
            3'b101:  res = {16'h0000, h};
            default: res = 32'h0000_0000;
        endcase
        return res;
    endfunction

    // Misalignment, illegal size encoding or out-of-range word index.
    function automatic logic access_fault(input logic [2:0] size,
                                          input logic [1:0] ofs,
                                          input logic       oor);
        logic f;
        case (size)
            3'b000, 3'b100: f = oor;
            3'b001, 3'b101: f = oor | ofs[0];
            3'b010:         f = oor | (ofs != 2'b00);
            default:        f = 1'b1;
        endcase
        return f;
    endfunction

    // In IDLE the access being accepted comes straight off the bus (needed
    // when there are no wait cycles); afterwards the latched copy is used.
    always_comb begin
        if (state_r == IDLE) begin
            cur_we_s   = bus.we;
            cur_size_s = bus.size;
            cur_addr_s = bus.addr;
            cur_wd_s   = bus.wd;
        end else begin
            cur_we_s   = we_r;
            cur_size_s = size_r;
            cur_addr_s = addr_r;
            cur_wd_s   = wd_r;
        end
    end

    // Decode the current access: fault, load result and byte-lane write data.
    always_comb begin
        idx_s     = cur_addr_s[IDX_W+1:2];
        oor_s     = ({2'b00, cur_addr_s[ADDR_W-1:2]} >= DEPTH_L);
        fault_s   = access_fault(cur_size_s, cur_addr_s[1:0], oor_s);
        resp_rd_s = (cur_we_s || fault_s) ? 32'h0000_0000
                  : extract_load(mem_r[idx_s], cur_size_s, cur_addr_s[1:0]);
        be_s      = 4'b0000;
        wdata_s   = 32'h0000_0000;
        case (cur_size_s[1:0])
            2'b00: begin
                be_s    = 4'b0001 << cur_addr_s[1:0];
                wdata_s = {4{cur_wd_s[7:0]}};
            end
            2'b01: begin
                be_s    = cur_addr_s[1] ? 4'b1100 : 4'b0011;
                wdata_s = {2{cur_wd_s[15:0]}};
            end
            2'b10: begin
                be_s    = 4'b1111;
                wdata_s = cur_wd_s;
            end
            default: begin
                be_s    = 4'b0000;
                wdata_s = 32'h0000_0000;
            end
        endcase
        mask_s = {{8{be_s[3]}}, {8{be_s[2]}}, {8{be_s[1]}}, {8{be_s[0]}}};
    end

    // A store commits exactly on the edge that moves the FSM into RESP.
    always_comb begin
        accept_s = bus.req && ready_r;
        if (!reset) begin
            enter_resp_s = 1'b0;
        end else if (state_r == WAIT) begin
            enter_resp_s = (cnt_r == 4'd0);
        end else if (state_r == IDLE) begin
            enter_resp_s = accept_s && (WAIT_CYCLES == 0);
        end else begin
            enter_resp_s = 1'b0;
        end
        write_en_s = enter_resp_s && cur_we_s && !fault_s;
    end

    // Storage array; reset intentionally leaves contents alone.
    always_ff @(posedge clk) begin
        if (write_en_s) begin
            mem_r[idx_s] <= (mem_r[idx_s] & ~mask_s) | (wdata_s & mask_s);
        end
    end

    // Access sequencer IDLE -> (WAIT x WAIT_CYCLES) -> RESP with registered outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= IDLE;
            cnt_r   <= 4'd0;
            we_r    <= 1'b0;
            size_r  <= 3'b000;
            addr_r  <= '0;
            wd_r    <= 32'h0000_0000;
            ready_r <= 1'b0;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
            rd_r    <= 32'h0000_0000;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        we_r    <= bus.we;
                        size_r  <= bus.size;
                        addr_r  <= bus.addr;
                        wd_r    <= bus.wd;
                        ready_r <= 1'b0;
                        if (WAIT_CYCLES == 0) begin
                            state_r <= RESP;
                            done_r  <= 1'b1;
                            err_r   <= fault_s;
                            rd_r    <= resp_rd_s;
                        end else begin
                            state_r <= WAIT;
                            cnt_r   <= CNT_LOAD;
                        end
                    end else begin
                        ready_r <= 1'b1;
                    end
                end
                WAIT: begin
                    if (cnt_r == 4'd0) begin
                        state_r <= RESP;
                        done_r  <= 1'b1;
                        err_r   <= fault_s;
                        rd_r    <= resp_rd_s;
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                RESP: begin
                    state_r <= IDLE;
                    ready_r <= 1'b1;
                    done_r  <= 1'b0;
                    err_r   <= 1'b0;
                    rd_r    <= 32'h0000_0000;
                end
                default: begin
                    state_r <= IDLE;
                    cnt_r   <= 4'd0;
                    ready_r <= 1'b0;
                    done_r  <= 1'b0;
                    err_r   <= 1'b0;
                    rd_r    <= 32'h0000_0000;
                end
            endcase
        end
    end

    assign bus.ready = ready_r;
    assign bus.done  = done_r;
    assign bus.rd    = rd_r;
    assign bus.err   = err_r;
endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: directed vector table, reset-abort and
// zero-latency streaming sequences, then random accesses against a
// byte-addressed reference memory.
module tb_data_mem_ctrl;
    localparam int DEPTH = 64;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    data_mem_ctrl_if #(.ADDR_W(32)) bus  ();
    data_mem_ctrl_if #(.ADDR_W(32)) bus0 ();

    data_mem_ctrl #(.ADDR_W(32), .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(2)) dut (
        .clk(clk), .reset(reset), .bus(bus));
    data_mem_ctrl #(.ADDR_W(32), .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset), .bus(bus0));

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] model_bytes [DEPTH*4];

    typedef struct {
        logic        we;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;
    vec_t tbl [19];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic bound_fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    // One access on the WAIT_CYCLES=2 controller; called at a sample point.
    task automatic access(input logic w, input logic [2:0] s, input logic [31:0] a,
                          input logic [31:0] d, output logic [31:0] r, output logic e,
                          output int lat);
        int guard;
        guard = 0;
        while (bus.ready !== 1'b1 && guard < 20) begin
            @(posedge clk); #1; guard++;
        end
        if (guard >= 20) bound_fail("ready_wait");
        bus.req = 1'b1; bus.we = w; bus.size = s; bus.addr = a; bus.wd = d;
        @(posedge clk); #1;
        bus.req = 1'b0; bus.we = ~w; bus.addr = $urandom; bus.wd = $urandom;
        bus.size = 3'($urandom_range(0, 7));
        lat = 1;
        while (bus.done !== 1'b1 && lat < 20) begin
            check("busy_ready_low", 64'(bus.ready), 64'd0);
            @(posedge clk); #1; lat++;
        end
        if (lat >= 20) bound_fail("done_wait");
        r = bus.rd;
        e = bus.err;
        @(posedge clk); #1;
        check("pulse_end", {31'd0, bus.done, bus.err, bus.rd}, 64'd0);
        check("ready_back", 64'(bus.ready), 64'd1);
    endtask

    // Reference: memory as a flat byte array, accesses by byte count.
    task automatic model_access(input logic w, input logic [2:0] s, input logic [31:0] a,
                                input logic [31:0] d, output logic [31:0] r, output logic e);
        int n;
        bit sgn;
        n = 0; sgn = 1'b0;
        case (s)
            3'd0: begin n = 1; sgn = 1'b1; end
            3'd1: begin n = 2; sgn = 1'b1; end
            3'd2: n = 4;
            3'd4: n = 1;
            3'd5: n = 2;
            default: n = 0;
        endcase
        r = 32'd0;
        if (n == 0) e = 1'b1;
        else if ((a % n) != 0) e = 1'b1;
        else if ((a / 4) >= DEPTH) e = 1'b1;
        else e = 1'b0;
        if (!e) begin
            for (int k = 0; k < n; k++) begin
                if (w) model_bytes[int'(a) + k] = d[8*k +: 8];
                else r = r | (32'(model_bytes[int'(a) + k]) << (8*k));
            end
            if (!w && sgn && r[8*n-1]) r = r | (32'hFFFF_FFFF << (8*n));
        end
    endtask

    logic [31:0] r, er, a, d;
    logic        e, ee, w;
    logic [2:0]  sz;
    logic [2:0]  valid_sizes [5];
    logic [2:0]  bad_sizes   [3];
    int          lat, ndone, n;

    initial begin
        tbl[0]  = '{1'b1, 3'b010, 32'h00, 32'h55AA55AA, 32'h0,        1'b0};
        tbl[1]  = '{1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0,        1'b0};
        tbl[2]  = '{1'b0, 3'b010, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0};
        tbl[3]  = '{1'b1, 3'b010, 32'h10, 32'h0,        32'h0,        1'b0};
        tbl[4]  = '{1'b1, 3'b000, 32'h13, 32'h80,       32'h0,        1'b0};
        tbl[5]  = '{1'b0, 3'b010, 32'h10, 32'h0,        32'h80000000, 1'b0};
        tbl[6]  = '{1'b0, 3'b000, 32'h13, 32'h0,        32'hFFFFFF80, 1'b0};
        tbl[7]  = '{1'b0, 3'b100, 32'h13, 32'h0,        32'h00000080, 1'b0};
        tbl[8]  = '{1'b1, 3'b010, 32'h20, 32'h11223344, 32'h0,        1'b0};
        tbl[9]  = '{1'b1, 3'b001, 32'h22, 32'h00008001, 32'h0,        1'b0};
        tbl[10] = '{1'b0, 3'b001, 32'h22, 32'h0,        32'hFFFF8001, 1'b0};
        tbl[11] = '{1'b0, 3'b101, 32'h22, 32'h0,        32'h00008001, 1'b0};
        tbl[12] = '{1'b0, 3'b010, 32'h20, 32'h0,        32'h80013344, 1'b0};
        tbl[13] = '{1'b1, 3'b010, 32'h11, 32'hCAFEF00D, 32'h0,        1'b1};
        tbl[14] = '{1'b0, 3'b001, 32'h21, 32'h0,        32'h0,        1'b1};
        tbl[15] = '{1'b0, 3'b011, 32'h10, 32'h0,        32'h0,        1'b1};
        tbl[16] = '{1'b1, 3'b010, 32'h100, 32'h12121212, 32'h0,       1'b1};
        tbl[17] = '{1'b0, 3'b010, 32'h10, 32'h0,        32'h80000000, 1'b0};
        tbl[18] = '{1'b0, 3'b010, 32'h00, 32'h0,        32'h55AA55AA, 1'b0};
        valid_sizes = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        bad_sizes   = '{3'b011, 3'b110, 3'b111};

        reset = 1'b0;
        bus.req = 1'b0;  bus.we = 1'b0;  bus.size = 3'b000;  bus.addr = 32'd0;  bus.wd = 32'd0;
        bus0.req = 1'b0; bus0.we = 1'b0; bus0.size = 3'b000; bus0.addr = 32'd0; bus0.wd = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ready", 64'(bus.ready), 64'd0);
        check("reset_outs", {31'd0, bus.done, bus.err, bus.rd}, 64'd0);
        check("reset_ready0", 64'(bus0.ready), 64'd0);
        reset = 1'b1;
        @(posedge clk); #1;
        check("ready_after_reset", 64'(bus.ready), 64'd1);
        check("ready_after_reset0", 64'(bus0.ready), 64'd1);

        // Zero-latency controller with req held high: one access every 2 cycles.
        bus0.req = 1'b1; bus0.we = 1'b1; bus0.size = 3'b010; bus0.addr = 32'd0; bus0.wd = 32'd0;
        ndone = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            check("wc0_ready", 64'(bus0.ready), 64'((i % 2) == 1));
            check("wc0_done", 64'(bus0.done), 64'((i % 2) == 0));
            check("wc0_store_rd", {31'd0, bus0.err, bus0.rd}, 64'd0);
            if (bus0.done) ndone++;
        end
        bus0.req = 1'b0;
        check("wc0_done_count", 64'(ndone), 64'd4);

        // Directed vectors.
        for (int i = 0; i < 19; i++) begin
            access(tbl[i].we, tbl[i].size, tbl[i].addr, tbl[i].wd, r, e, lat);
            check($sformatf("vec%0d_rd", i), 64'(r), 64'(tbl[i].exp_rd));
            check($sformatf("vec%0d_err", i), 64'(e), 64'(tbl[i].exp_err));
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'd3);
        end

        // Reset during WAIT aborts a store.
        bus.req = 1'b1; bus.we = 1'b1; bus.size = 3'b010; bus.addr = 32'h10; bus.wd = 32'h12345678;
        @(posedge clk); #1;
        bus.req = 1'b0;
        check("abort_in_wait", 64'(bus.ready), 64'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        check("abort_no_done1", {62'd0, bus.done, bus.ready}, 64'd0);
        @(posedge clk); #1;
        check("abort_no_done2", {62'd0, bus.done, bus.ready}, 64'd0);
        reset = 1'b1;
        @(posedge clk); #1;
        check("abort_ready", 64'(bus.ready), 64'd1);
        check("abort_no_done3", 64'(bus.done), 64'd0);
        access(1'b0, 3'b010, 32'h10, 32'h0, r, e, lat);
        check("abort_mem_unchanged", 64'(r), 64'h80000000);

        // Random phase: fill every word, then mixed accesses vs. the model.
        for (int wi = 0; wi < DEPTH; wi++) begin
            d = $urandom;
            model_access(1'b1, 3'b010, 32'(wi * 4), d, er, ee);
            access(1'b1, 3'b010, 32'(wi * 4), d, r, e, lat);
            check("fill_err", 64'(e), 64'(ee));
        end
        for (int it = 0; it < 300; it++) begin
            w = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) sz = bad_sizes[$urandom_range(0, 2)];
            else sz = valid_sizes[$urandom_range(0, 4)];
            a = 32'($urandom_range(0, DEPTH * 4 + 7));
            n = (sz[1:0] == 2'b10) ? 4 : ((sz[1:0] == 2'b01) ? 2 : 1);
            if ($urandom_range(0, 3) != 0) a = a - (a % n);
            d = $urandom;
            model_access(w, sz, a, d, er, ee);
            access(w, sz, a, d, r, e, lat);
            check($sformatf("rand%0d_rd", it), 64'(r), 64'(er));
            check($sformatf("rand%0d_err", it), 64'(e), 64'(ee));
            check($sformatf("rand%0d_latency", it), 64'(lat), 64'd3);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 32: byte-address width.
REQ-002 SHALL have parameter DEPTH_WORDS, default 1024: number of 32-bit words of storage.
REQ-003 SHALL have parameter WAIT_CYCLES, default 2: extra latency cycles per access, range 0..15.
REQ-004 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1: synchronous, active-low reset.
REQ-006 SHALL have port req, input, 1: access request.
REQ-007 SHALL have port we, input, 1: 1 = store, 0 = load.
REQ-008 SHALL have port size, input, 3: 000 byte signed, 001 half signed, 010 word, 100 byte unsigned, 101 half unsigned.
REQ-009 SHALL have port addr, input, ADDR_W: byte address.
REQ-010 SHALL have port wd, input, 32: store data, right-aligned.
REQ-011 SHALL have port ready, output, 1: controller accepts a request this cycle.
REQ-012 SHALL have port done, output, 1: one-cycle completion pulse.
REQ-013 SHALL have port rd, output, 32: load result, valid only while done=1.
REQ-014 SHALL have port err, output, 1: access faulted, valid only while done=1.

Function
REQ-015 SHALL implement an FSM with states IDLE, WAIT, RESP; ready=1 only in IDLE.
REQ-016 SHALL accept a request on an edge where req=1 and ready=1, latching we, size, addr and wd; inputs are ignored at all other times.
REQ-017 SHALL transition IDLE->WAIT on acceptance when WAIT_CYCLES>0, and IDLE->RESP when WAIT_CYCLES=0.
REQ-018 SHALL hold WAIT for exactly WAIT_CYCLES cycles, counted by a down-counter loaded at acceptance, then go to RESP.
REQ-019 SHALL assert done for exactly the single RESP cycle, then return to IDLE; done is therefore first high WAIT_CYCLES+1 cycles after the accepting edge.
REQ-020 SHALL drop ready from the cycle after acceptance until the cycle after done, so back-to-back throughput is one access per WAIT_CYCLES+2 cycles.
REQ-021 SHALL store little-endian: byte at addr[1:0] goes to lane addr[1:0]; half at addr[1]=0 goes to lanes 1:0, at addr[1]=1 goes to lanes 3:2; word writes all lanes.
REQ-022 SHALL commit a store on the edge that enters RESP, writing only the addressed lanes; other lanes are unchanged.
REQ-023 SHALL return for loads the addressed byte or half, sign-extended for sizes 000/001 and zero-extended for sizes 100/101; word loads return the full word.
REQ-024 SHALL flag err=1 in RESP for any of: half with addr[0]=1; word with addr[1:0]!=00; size 011, 110 or 111; word index addr>>2 >= DEPTH_WORDS.
REQ-025 SHALL, on a faulting access, suppress the memory write, drive rd=0 and still complete with the normal latency.
REQ-026 SHALL drive rd=0 and err=0 whenever done=0, and rd=0 on stores.
REQ-027 SHALL return, for a load issued after a store to the same address completes, the stored value; there is no write buffering.

Reset
REQ-028 SHALL, on a rising edge with reset=0, force state IDLE, counter 0, done=0, err=0 and rd=0.
REQ-029 SHALL hold ready=0 while reset=0, with ready=1 on the first cycle after reset deasserts.
REQ-030 SHALL abort an in-flight access when reset is asserted in WAIT, so no store is committed and no done pulse appears.
REQ-031 SHALL leave memory contents unchanged by reset; contents after power-up are undefined.

Verification
REQ-032 SHALL pass this case: WAIT_CYCLES=2, store word 0xDEADBEEF at 0x10, then load word at 0x10 -> each done is 3 cycles after acceptance, load rd=0xDEADBEEF, err=0.
REQ-033 SHALL pass this case: store byte 0x80 at 0x13 over word 0x00000000, then load word 0x10, load signed byte 0x13 and load unsigned byte 0x13 -> rd=0x80000000, 0xFFFFFF80 and 0x00000080.
REQ-034 SHALL pass this case: store half 0x8001 at 0x22, then load signed half 0x22 and load unsigned half 0x22 -> rd=0xFFFF8001 and 0x00008001; lanes 1:0 of word 0x20 unchanged.
REQ-035 SHALL pass this case: store word at 0x11, load half at 0x21, size 011, and addr=DEPTH_WORDS*4 -> each gives done with err=1, rd=0, and a reload of 0x10 shows memory unchanged.
REQ-036 SHALL pass this case: store accepted, then reset=0 asserted during WAIT -> no done pulse, target word unchanged, ready=1 the cycle after reset releases.
REQ-037 SHALL pass this case: WAIT_CYCLES=0 with req held high continuously -> done every 2nd cycle, ready alternating 1/0, and req ignored while ready=0.
